pe_multicast_ctrl: RTL and testbench
====================================

// Module: pe_multicast_ctrl
// PURPOSE
//   Per-PE multicast controller directly upstream of each PE's ifmap input.
//   Snoops a shared tagged ifmap bus, accepts items whose tag matches its
//   programmed ID (or the broadcast tag), and buffers them in a small FIFO.
//   It delivers them to the PE over the ifmap_enable/ifmap_ready handshake.
//   Non-matching MCs never stall the shared bus.
// PARAMETERS
//   DATA_SIZE   8  bits per data lane
//   DATA_NUM    1  lanes per bus item (1 for ifmap)
//   ID_BIT      5  tag/ID width; all-ones tag = broadcast
//   FIFO_DEPTH  4  buffer entries, power of 2, >=2
//   CNT_BIT     16 forwarded-item counter width
// PORTS
//   clk        in   1                    clock
//   rst        in   1                    async reset, active-high
//   set_id     in   1                    latch id_in as this MC's ID
//   id_in      in   ID_BIT               ID value for set_id
//   bus_tag    in   ID_BIT               destination tag of current bus item
//   bus_data   in   DATA_NUM*DATA_SIZE   bus payload
//   bus_valid  in   1                    bus item valid
//   bus_ready  out  1                    this MC does not block the bus
//   pe_data    out  DATA_NUM*DATA_SIZE   to PE ifmap
//   pe_enable  out  1                    to PE ifmap_enable (valid)
//   pe_ready   in   1                    from PE ifmap_ready
//   cfg_valid  out  1                    ID programmed
//   fwd_cnt    out  CNT_BIT              items delivered to PE since set_id/reset
// BEHAVIOUR
//   - Reset, async and immediate: cfg_id=0, cfg_valid=0 (state UNCONF), FIFO
//     empty, pe_enable=0, pe_data=0, fwd_cnt=0, bus_ready=1.
//   - FSM: UNCONF -> ACTIVE on set_id. ACTIVE -> ACTIVE on set_id (re-program).
//     Only rst returns to UNCONF.
//   - match = cfg_valid & (bus_tag==cfg_id | bus_tag=={ID_BIT{1}}). Uses the
//     registered cfg_id, so a set_id cycle still matches against the old ID.
//   - bus_ready = ~match | ~full. Combinational from bus_tag/state only.
//     bus_ready never depends on pe_ready; no same-cycle slot reuse when full.
//   - push = bus_valid & match & ~full. pop = pe_enable & pe_ready.
//   - pe_enable = ~empty. pe_data = FIFO head.
//   - pe_data is 0 when empty; it must not change while pe_enable=1 & ~pe_ready.
//   - Latency: item pushed at edge N appears on pe_enable/pe_data after edge N.
//     That is 1 cycle when the FIFO was empty.
//   - Order is strictly FIFO. Simultaneous push+pop leaves the count unchanged.
//   - Push+pop is legal at count=0? No: a pop requires ~empty.
//   - Full: matching items are back-pressured (bus_ready=0) and never dropped.
//   - Non-matching valid items are ignored, with bus_ready=1.
//   - Pointers wrap modulo FIFO_DEPTH. Count uses an extra bit to tell
//     full from empty.
//   - set_id with a non-empty FIFO: buffered items are kept and still drained
//     to the PE. Only subsequent matching uses the new ID.
//   - fwd_cnt += 1 per pop, wrapping at 2^CNT_BIT. set_id clears it to 0.
//     On set_id+pop in the same cycle the result is 0 (clear wins).
//   - Reset mid-transfer discards FIFO contents. bus_ready returns to 1 and
//     pe_enable to 0 asynchronously.
// TESTING
//   1. Unconfigured: bus_valid=1, tag=3, data=0x11 -> bus_ready=1, pe_enable
//      stays 0.
//   2. set_id id_in=5; send tags 5,4,5 with data 0xA1,0xB2,0xC3, pe_ready=1 ->
//      PE receives 0xA1 then 0xC3, in order. Each appears 1 cycle after push.
//      fwd_cnt=2.
//   3. ID=5, pe_ready=0, push 4 items tag 5 -> 5th has bus_ready=0.
//      Raise pe_ready -> PE gets all 5 in order, no loss.
//   4. ID=5, FIFO full, tag=7 item -> bus_ready=1 (not blocked), item ignored.
//      Tag 31 (bcast) item -> bus_ready=0 until a slot frees.
//   5. 2 items buffered, set_id id_in=9 -> both still delivered, fwd_cnt=0
//      then 1,2. Tag 5 is now ignored and tag 9 is accepted.
//   6. rst pulse mid-stream with 3 items buffered -> pe_enable=0 immediately.
//      cfg_valid=0, fwd_cnt=0, and no stale data after release.

Source files
------------

// File: rtl/pe_multicast_ctrl.sv
// Per-PE multicast controller: snoops the shared tagged ifmap bus, buffers items
// addressed to this PE (or broadcast) and hands them to the PE over a valid/ready port.
module pe_multicast_ctrl #(
   parameter int DATA_SIZE  = 8,
   parameter int DATA_NUM   = 1,
   parameter int ID_BIT     = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_BIT    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          set_id,
   input  logic [ID_BIT-1:0]             id_in,
   input  logic [ID_BIT-1:0]             bus_tag,
   input  logic [DATA_NUM*DATA_SIZE-1:0] bus_data,
   input  logic                          bus_valid,
   output logic                          bus_ready,
   output logic [DATA_NUM*DATA_SIZE-1:0] pe_data,
   output logic                          pe_enable,
   input  logic                          pe_ready,
   output logic                          cfg_valid,
   output logic [CNT_BIT-1:0]            fwd_cnt
);

   localparam int W       = DATA_NUM * DATA_SIZE;
   localparam int PTR_BIT = $clog2(FIFO_DEPTH);

   typedef enum logic [0:0] {
      UNCONF = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ID_BIT-1:0]     cfg_id;
   logic [W-1:0]          mem [FIFO_DEPTH];
   logic [PTR_BIT-1:0]    wr_ptr;
   logic [PTR_BIT-1:0]    rd_ptr;
   logic [PTR_BIT:0]      count;
   logic                  full;
   logic                  empty;
   logic                  match;
   logic                  push;
   logic                  pop;

   assign full      = (count == (PTR_BIT+1)'(FIFO_DEPTH));
   assign empty     = (count == {(PTR_BIT+1){1'b0}});
   assign cfg_valid = (state == ACTIVE);

   // Matching deliberately uses the registered ID, so a set_id cycle still sees the old one.
   assign match     = cfg_valid & ((bus_tag == cfg_id) | (bus_tag == {ID_BIT{1'b1}}));
   assign bus_ready = ~match | ~full;
   assign push      = bus_valid & match & ~full;
   assign pe_enable = ~empty;
   assign pop       = pe_enable & pe_ready;
   assign pe_data   = empty ? {W{1'b0}} : mem[rd_ptr];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= UNCONF;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: once configured only reset leaves ACTIVE.
   always_comb begin
      state_next = state;
      case (state)
         UNCONF: begin
            if (set_id) begin
               state_next = ACTIVE;
            end else begin
               state_next = UNCONF;
            end
         end
         ACTIVE:  state_next = ACTIVE;
         default: state_next = UNCONF;
      endcase
   end

   // Programmed ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_id <= {ID_BIT{1'b0}};
      end else if (set_id) begin
         cfg_id <= id_in;
      end
   end

   // FIFO storage; cleared on reset so no stale payload survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= {W{1'b0}};
         end
      end else if (push) begin
         mem[wr_ptr] <= bus_data;
      end
   end

   // FIFO pointers and occupancy; the extra count bit separates full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {PTR_BIT{1'b0}};
         rd_ptr <= {PTR_BIT{1'b0}};
         count  <= {(PTR_BIT+1){1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + {{(PTR_BIT-1){1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{(PTR_BIT-1){1'b0}}, 1'b1};
         end
         case ({push, pop})
            2'b10:   count <= count + {{PTR_BIT{1'b0}}, 1'b1};
            2'b01:   count <= count - {{PTR_BIT{1'b0}}, 1'b1};
            default: count <= count;
         endcase
      end
   end

   // Delivered-item counter; a simultaneous set_id clear beats the increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_cnt <= {CNT_BIT{1'b0}};
      end else if (set_id) begin
         fwd_cnt <= {CNT_BIT{1'b0}};
      end else if (pop) begin
         fwd_cnt <= fwd_cnt + {{(CNT_BIT-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pe_multicast_ctrl.sv
// Self-checking bench for pe_multicast_ctrl: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pe_multicast_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        set_id = 1'b0;
   logic [4:0]  id_in = 5'd0;
   logic [4:0]  bus_tag = 5'd0;
   logic [7:0]  bus_data = 8'd0;
   logic        bus_valid = 1'b0;
   logic        bus_ready;
   logic [7:0]  pe_data;
   logic        pe_enable;
   logic        pe_ready = 1'b0;
   logic        cfg_valid;
   logic [15:0] fwd_cnt;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [7:0]  q[$];
   logic        m_valid = 1'b0;
   logic [4:0]  m_id = 5'd0;
   logic [15:0] m_cnt = 16'd0;
   logic [7:0]  got[$];

   pe_multicast_ctrl #(
      .DATA_SIZE(8), .DATA_NUM(1), .ID_BIT(5), .FIFO_DEPTH(DEPTH), .CNT_BIT(16)
   ) dut (
      .clk(clk), .rst(rst), .set_id(set_id), .id_in(id_in),
      .bus_tag(bus_tag), .bus_data(bus_data), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .pe_data(pe_data), .pe_enable(pe_enable),
      .pe_ready(pe_ready), .cfg_valid(cfg_valid), .fwd_cnt(fwd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_match(input logic [4:0] tag);
      return m_valid && (tag == m_id || tag == 5'd31);
   endfunction

   // reference model: advances on each clock edge, cleared by reset
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_id    = 5'd0;
            m_cnt   = 16'd0;
         end else begin
            logic do_push;
            logic do_pop;
            do_push = bus_valid && m_match(bus_tag) && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && pe_ready;
            if (do_pop) begin
               void'(q.pop_front());
               m_cnt = m_cnt + 16'd1;
            end
            if (do_push) q.push_back(bus_data);
            if (set_id) begin
               m_valid = 1'b1;
               m_id    = id_in;
               m_cnt   = 16'd0;
            end
         end
      end
   end

   // per-cycle comparison against the model, and capture of delivered items
   initial begin
      forever begin
         @(negedge clk);
         chk("bus_ready", {31'd0, bus_ready}, {31'd0, !m_match(bus_tag) || (q.size() < DEPTH)});
         chk("pe_enable", {31'd0, pe_enable}, {31'd0, q.size() > 0});
         chk("pe_data", {24'd0, pe_data}, {24'd0, (q.size() > 0) ? q[0] : 8'd0});
         chk("cfg_valid", {31'd0, cfg_valid}, {31'd0, m_valid});
         chk("fwd_cnt", {16'd0, fwd_cnt}, {16'd0, m_cnt});
         if (pe_enable && pe_ready) got.push_back(pe_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [4:0] tag, input logic [7:0] data);
      logic ok;
      ok = 1'b0;
      bus_valid = 1'b1;
      bus_tag   = tag;
      bus_data  = data;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      step();
      bus_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      step();
      step();
      chk("rst_cfg_valid", {31'd0, cfg_valid}, 32'd0);
      chk("rst_bus_ready", {31'd0, bus_ready}, 32'd1);
      chk("rst_pe_enable", {31'd0, pe_enable}, 32'd0);
      rst = 1'b0;

      // unconfigured: never blocks, never accepts
      step();
      bus_valid = 1'b1; bus_tag = 5'd3; bus_data = 8'h11;
      #1 chk("unconf_bus_ready", {31'd0, bus_ready}, 32'd1);
      step();
      bus_valid = 1'b0;
      chk("unconf_pe_enable", {31'd0, pe_enable}, 32'd0);

      // program ID 5, filter tags, one-cycle latency
      set_id = 1'b1; id_in = 5'd5; pe_ready = 1'b1;
      step();
      set_id = 1'b0;
      chk("cfg_valid_set", {31'd0, cfg_valid}, 32'd1);
      got.delete();
      send(5'd5, 8'hA1);
      chk("latency_data", {24'd0, pe_data}, 32'hA1);
      send(5'd4, 8'hB2);
      send(5'd5, 8'hC3);
      repeat (3) step();
      chk("t2_count", got.size(), 32'd2);
      if (got.size() == 2) begin
         chk("t2_item0", {24'd0, got[0]}, 32'hA1);
         chk("t2_item1", {24'd0, got[1]}, 32'hC3);
      end
      chk("t2_fwd_cnt", {16'd0, fwd_cnt}, 32'd2);

      // fill FIFO with PE stalled, then check back-pressure rules
      pe_ready = 1'b0;
      got.delete();
      for (int d = 1; d <= 4; d++) send(5'd5, 8'(d));
      bus_valid = 1'b1; bus_tag = 5'd5; bus_data = 8'd5;
      #1 chk("full_match_ready", {31'd0, bus_ready}, 32'd0);
      step();
      chk("full_hold_ready", {31'd0, bus_ready}, 32'd0);
      bus_tag = 5'd7; bus_data = 8'h77;
      #1 chk("full_other_ready", {31'd0, bus_ready}, 32'd1);
      step();
      bus_tag = 5'd31; bus_data = 8'h99;
      #1 chk("full_bcast_ready", {31'd0, bus_ready}, 32'd0);
      step();
      bus_valid = 1'b0;
      pe_ready = 1'b1;
      send(5'd5, 8'd5);
      repeat (8) step();
      chk("t3_count", got.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) chk("t3_item", {24'd0, got[i]}, 32'(i + 1));
      end
      send(5'd31, 8'h99);
      repeat (3) step();
      if (got.size() == 6) chk("bcast_item", {24'd0, got[5]}, 32'h99);
      else chk("bcast_count", got.size(), 32'd6);
      chk("t4_fwd_cnt", {16'd0, fwd_cnt}, 32'd8);

      // re-program with items buffered
      pe_ready = 1'b0;
      got.delete();
      send(5'd5, 8'h51);
      send(5'd5, 8'h52);
      set_id = 1'b1; id_in = 5'd9;
      step();
      set_id = 1'b0;
      chk("reprog_fwd_cnt", {16'd0, fwd_cnt}, 32'd0);
      chk("reprog_pe_enable", {31'd0, pe_enable}, 32'd1);
      chk("reprog_pe_data", {24'd0, pe_data}, 32'h51);
      pe_ready = 1'b1;
      repeat (3) step();
      chk("reprog_drained", {16'd0, fwd_cnt}, 32'd2);
      chk("reprog_count", got.size(), 32'd2);
      if (got.size() == 2) chk("reprog_item1", {24'd0, got[1]}, 32'h52);
      bus_valid = 1'b1; bus_tag = 5'd5; bus_data = 8'h55;
      step();
      bus_valid = 1'b0;
      chk("old_id_ignored", {31'd0, pe_enable}, 32'd0);
      send(5'd9, 8'h90);
      repeat (2) step();
      if (got.size() == 3) chk("new_id_item", {24'd0, got[2]}, 32'h90);
      else chk("new_id_count", got.size(), 32'd3);
      chk("t5_fwd_cnt", {16'd0, fwd_cnt}, 32'd3);

      // reset mid-stream
      pe_ready = 1'b0;
      send(5'd9, 8'h01);
      send(5'd9, 8'h02);
      send(5'd9, 8'h03);
      chk("pre_rst_enable", {31'd0, pe_enable}, 32'd1);
      step();
      rst = 1'b1;
      #1;
      chk("rst_async_enable", {31'd0, pe_enable}, 32'd0);
      chk("rst_async_ready", {31'd0, bus_ready}, 32'd1);
      chk("rst_async_cfg", {31'd0, cfg_valid}, 32'd0);
      chk("rst_async_cnt", {16'd0, fwd_cnt}, 32'd0);
      chk("rst_async_data", {24'd0, pe_data}, 32'd0);
      step();
      rst = 1'b0;
      bus_valid = 1'b1; bus_tag = 5'd9; bus_data = 8'h44;
      step();
      bus_valid = 1'b0;
      chk("post_rst_enable", {31'd0, pe_enable}, 32'd0);
      chk("post_rst_data", {24'd0, pe_data}, 32'd0);
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
